cb_addr_seq: RTL and testbench

Sequencer that drives the CB address shift chain of an L-bank systolic array. It accepts one burst request (base address, row count, group length) over a valid/ready handshake. It then streams one row base address per cycle on `din`, with the matching `group_cnt_0` flag and a diagonally skewed `CB_en` bank-enable pattern. After the last row it drains the pipeline and pulses `done`. It sits between the array control FSM and the CB address shifter, whose `din`/`CB_en`/`group_cnt_0` inputs it feeds directly.

---
 rtl/cb_addr_seq.sv | 114 +++++++++++
 tb/tb_cb_addr_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_addr_seq.sv
// CB address-chain sequencer: issues one row base address per cycle
// with group-start flags and a skewed bank-enable pattern.
module cb_addr_seq #(
   parameter int L       = 4,
   parameter int CB_AW   = 19,
   parameter int ROW_LEN = 10,
   parameter int RW      = 10,
   parameter int GW      = 8
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             req_vld,
   output logic             req_rdy,
   input  logic [CB_AW-1:0] req_base,
   input  logic [RW-1:0]    req_rows,
   input  logic [GW-1:0]    req_grp,
   input  logic             abort,
   output logic [CB_AW-1:0] din,
   output logic             cb_vld,
   output logic             group_cnt_0,
   output logic [L-2:0]     CB_en,
   output logic             busy,
   output logic             done
);

   localparam int DW = (L > 2) ? $clog2(L) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CB_AW-1:0] STRIDE    = CB_AW'(ROW_LEN);
   localparam logic [DW-1:0]    DRAIN_END = DW'(L - 2);

   logic [1:0]    state;
   logic [RW-1:0] rows;
   logic [GW-1:0] grp;
   logic [RW-1:0] k;
   logic [GW-1:0] g;
   logic [DW-1:0] dcnt;
   logic          last_row;
   logic          g_wrap;

   assign last_row = (k == rows - 1'b1);
   // G==0 never wraps, so only row 0 is flagged
   assign g_wrap   = (grp != '0) && (g == grp - 1'b1);

   always_ff @(posedge clk) begin
      if (!sys_rst || abort) begin
         state       <= S_IDLE;
         rows        <= '0;
         grp         <= '0;
         k           <= '0;
         g           <= '0;
         dcnt        <= '0;
         din         <= '0;
         cb_vld      <= 1'b0;
         group_cnt_0 <= 1'b0;
         CB_en       <= '0;
      end else begin
         CB_en <= {CB_en[L-3:0], cb_vld};
         unique case (state)
            S_IDLE: begin
               if (req_vld) begin
                  rows <= req_rows;
                  grp  <= req_grp;
                  k    <= '0;
                  g    <= '0;
                  dcnt <= '0;
                  if (req_rows == '0) begin
                     state <= S_DONE;
                  end else begin
                     state       <= S_ISSUE;
                     din         <= req_base;
                     cb_vld      <= 1'b1;
                     group_cnt_0 <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (last_row) begin
                  state       <= S_DRAIN;
                  cb_vld      <= 1'b0;
                  group_cnt_0 <= 1'b0;
               end else begin
                  k           <= k + 1'b1;
                  din         <= din + STRIDE;
                  g           <= g_wrap ? '0 : g + 1'b1;
                  group_cnt_0 <= g_wrap;
               end
            end
            S_DRAIN: begin
               if (dcnt == DRAIN_END) begin
                  state <= S_DONE;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_rdy = (state == S_IDLE) && sys_rst;
   assign busy    = (state == S_ISSUE) || (state == S_DRAIN);
   assign done    = (state == S_DONE);

endmodule

// File: tb/tb_cb_addr_seq.sv
// Bench for cb_addr_seq: burst table, abort/reset and back-to-back
// sequences, and random traffic against a cycle-offset reference model.
module tb_cb_addr_seq;

   localparam int L  = 4;
   localparam int AW = 19;
   localparam int RL = 10;
   localparam int RW = 10;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          sys_rst = 1'b0;
   logic          req_vld = 1'b0;
   logic          req_rdy;
   logic [AW-1:0] req_base = '0;
   logic [RW-1:0] req_rows = '0;
   logic [GW-1:0] req_grp = '0;
   logic          abort = 1'b0;
   logic [AW-1:0] din;
   logic          cb_vld;
   logic          group_cnt_0;
   logic [L-2:0]  CB_en;
   logic          busy;
   logic          done;

   cb_addr_seq #(
      .L(L), .CB_AW(AW), .ROW_LEN(RL), .RW(RW), .GW(GW)
   ) dut (
      .clk(clk),
      .sys_rst(sys_rst),
      .req_vld(req_vld),
      .req_rdy(req_rdy),
      .req_base(req_base),
      .req_rows(req_rows),
      .req_grp(req_grp),
      .abort(abort),
      .din(din),
      .cb_vld(cb_vld),
      .group_cnt_0(group_cnt_0),
      .CB_en(CB_en),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rdy;
      logic [AW-1:0] din;
      logic          vld;
      logic          gc0;
      logic [L-2:0]  en;
      logic          busy;
      logic          done;
   } out_t;

   typedef struct {
      int base;
      int n;
      int g;
      int din0;
      int dinl;
      int pat;
      int donec;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   chk_en = 0;
   out_t s;

   // reference: burst described by its acceptance cycle and parameters
   bit m_act = 0;
   int m_t0 = 0;
   int m_base = 0;
   int m_n = 0;
   int m_g = 0;
   int m_hold = 0;

   function automatic out_t model_out();
      out_t e;
      int   c;
      e     = '0;
      e.din = AW'(m_hold);
      e.rdy = sys_rst;
      if (m_act) begin
         c     = cyc - m_t0;
         e.rdy = sys_rst && (c >= ((m_n == 0) ? 2 : m_n + L + 1));
         if (m_n == 0) begin
            e.done = (c == 1);
         end else begin
            e.vld = (c >= 1) && (c <= m_n);
            if (e.vld)
               e.din = AW'(m_base + (c - 1) * RL);
            else if (c > m_n)
               e.din = AW'(m_base + (m_n - 1) * RL);
            if (m_g == 0)
               e.gc0 = e.vld && (c == 1);
            else
               e.gc0 = e.vld && (((c - 1) % m_g) == 0);
            for (int i = 0; i < L - 1; i++)
               e.en[i] = (c >= i + 2) && (c <= m_n + i + 1);
            e.busy = (c >= 1) && (c <= m_n + L - 1);
            e.done = (c == m_n + L);
         end
      end
      return e;
   endfunction

   task automatic check(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // one clock cycle: compare outputs, then advance the model at the edge
   task automatic tick();
      out_t e;
      @(negedge clk);
      s = {req_rdy, din, cb_vld, group_cnt_0, CB_en, busy, done};
      if (chk_en) begin
         e = model_out();
         checks++;
         if (s !== e) begin
            errors++;
            $display("FAIL model cyc=%0d got rdy=%b din=%0d vld=%b g0=%b en=%b busy=%b done=%b exp rdy=%b din=%0d vld=%b g0=%b en=%b busy=%b done=%b",
                     cyc, s.rdy, s.din, s.vld, s.gc0, s.en, s.busy, s.done,
                     e.rdy, e.din, e.vld, e.gc0, e.en, e.busy, e.done);
         end
      end
      @(posedge clk);
      e = model_out();
      if (!sys_rst || abort) begin
         m_act  = 0;
         m_hold = 0;
      end else if (req_vld && e.rdy) begin
         m_act  = 1;
         m_t0   = cyc;
         m_hold = int'(e.din);
         m_base = int'(req_base);
         m_n    = int'(req_rows);
         m_g    = int'(req_grp);
      end
      cyc++;
      chk_en = 1;
      #1;
   endtask

   task automatic wait_rdy(input string nm);
      int t;
      t = 0;
      while (!req_rdy && t < 60) begin
         tick();
         t++;
      end
      if (!req_rdy) begin
         errors++;
         $display("FAIL %s: timeout waiting for req_rdy got 0 expected 1", nm);
      end
   endtask

   task automatic run_burst(input int base, input int n, input int g,
                            output int first, output int last,
                            output int pat, output int donec);
      wait_rdy("burst_rdy");
      req_vld  = 1'b1;
      req_base = AW'(base);
      req_rows = RW'(n);
      req_grp  = GW'(g);
      tick();
      req_vld = 1'b0;
      first = 0;
      last  = 0;
      pat   = 0;
      donec = -1;
      for (int j = 1; j <= 40 && donec < 0; j++) begin
         tick();
         if (s.vld) begin
            if (j == 1) first = int'(s.din);
            last = int'(s.din);
            if (j <= 8 && s.gc0) pat = pat | (1 << (j - 1));
         end
         if (s.done) donec = j;
      end
   endtask

   vec_t tbl[6];

   initial begin
      int f, l, p, d;
      int fr, f3;
      tbl[0] = '{100, 3, 3, 100, 120, 32'h01, 7};
      tbl[1] = '{0, 5, 2, 0, 40, 32'h15, 9};
      tbl[2] = '{50, 4, 0, 50, 80, 32'h01, 8};
      tbl[3] = '{524283, 3, 1, 524283, 15, 32'h07, 7};
      tbl[4] = '{7, 0, 5, 0, 0, 32'h00, 1};
      tbl[5] = '{1000, 1, 0, 1000, 1000, 32'h01, 5};

      sys_rst = 1'b0;
      repeat (3) tick();
      check("rst_rdy", int'(s.rdy), 0);
      check("rst_busy", int'(s.busy), 0);
      sys_rst = 1'b1;
      tick();
      check("idle_rdy", int'(s.rdy), 1);
      check("idle_en", int'(s.en), 0);

      for (int i = 0; i < 6; i++) begin
         run_burst(tbl[i].base, tbl[i].n, tbl[i].g, f, l, p, d);
         check($sformatf("t%0d_din0", i), f, tbl[i].din0);
         check($sformatf("t%0d_dinl", i), l, tbl[i].dinl);
         check($sformatf("t%0d_gpat", i), p, tbl[i].pat);
         check($sformatf("t%0d_done", i), d, tbl[i].donec);
      end

      // cancel in cycle 2 of an N=6 burst, by abort then by reset
      for (int v = 0; v < 2; v++) begin
         wait_rdy("cancel_rdy");
         req_vld  = 1'b1;
         req_base = AW'(3000);
         req_rows = RW'(6);
         req_grp  = GW'(2);
         tick();
         req_vld = 1'b0;
         tick();
         if (v == 0) abort = 1'b1;
         else sys_rst = 1'b0;
         tick();
         abort    = 1'b0;
         sys_rst  = 1'b1;
         req_vld  = 1'b1;
         req_base = AW'(4000);
         req_rows = RW'(2);
         req_grp  = GW'(0);
         tick();
         req_vld = 1'b0;
         check($sformatf("cancel%0d_c3", v), int'(s),
               int'(out_t'{1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0}));
         tick();
         check($sformatf("cancel%0d_vld", v), int'(s.vld), 1);
         check($sformatf("cancel%0d_din", v), int'(s.din), 4000);
         wait_rdy("cancel_end");
      end

      // back-to-back with req_vld held high
      wait_rdy("b2b_rdy");
      req_vld  = 1'b1;
      req_base = AW'(200);
      req_rows = RW'(2);
      req_grp  = GW'(1);
      tick();
      req_base = AW'(300);
      fr = -1;
      f3 = -1;
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (s.rdy && fr < 0) fr = j;
         if (s.vld && s.din == AW'(300) && f3 < 0) f3 = j;
         if (j == 7) req_vld = 1'b0;
      end
      check("b2b_accept", fr, 7);
      check("b2b_newbase", f3, 8);
      wait_rdy("b2b_end");

      // random traffic, occasional abort and reset
      for (int j = 0; j < 800; j++) begin
         sys_rst  = ($urandom % 120) != 0;
         abort    = ($urandom % 40) == 0;
         req_vld  = ($urandom % 2) != 0;
         req_base = AW'($urandom);
         req_rows = RW'($urandom_range(0, 9));
         req_grp  = GW'($urandom_range(0, 4));
         tick();
      end
      sys_rst = 1'b1;
      abort   = 1'b0;
      req_vld = 1'b0;
      repeat (20) tick();
      check("final_rdy", int'(s.rdy), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
